// File: rtl/result_byte_reader.sv
`default_nettype none
// ============================================================================
// Module   : result_byte_reader
// Captures a result word plus carry and shows it one byte at a time, LSB
// first, stepped by a next/unlock handshake. Optional macro AUTO_SCROLL_EN
// adds a timed auto-advance every SCROLL_DIV cycles.
// Revision : 1.0 - initial release
// ============================================================================
module result_byte_reader #(
  parameter int WIDTH      = 32,
  parameter int SCROLL_DIV = 50_000_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_i,
  input  logic [WIDTH-1:0]             result_i,
  input  logic                         carry_i,
  input  logic                         next_i,
  input  logic                         unlock_i,
  output logic [7:0]                   out_o,
  output logic [$clog2(WIDTH/8)-1:0]   byte_idx_o,
  output logic                         carryled_o,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int c_NB = WIDTH / 8;
  localparam int c_IW = $clog2(c_NB);
  localparam logic [c_IW-1:0] c_LAST = c_IW'(c_NB - 1);

  localparam logic [1:0] c_S_IDLE   = 2'd0;
  localparam logic [1:0] c_S_SHOW   = 2'd1;
  localparam logic [1:0] c_S_LOCKED = 2'd2;
  localparam logic [1:0] c_S_DONE   = 2'd3;

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             carry_q,  carry_d;
  logic [c_IW-1:0]  idx_q,    idx_d;
  logic             w_manual;
  logic             w_tick;
  logic             w_active;

  assign w_active = (state_q == c_S_SHOW) || (state_q == c_S_LOCKED);
  assign w_manual = (state_q == c_S_SHOW) && next_i;

`ifdef AUTO_SCROLL_EN
  localparam int c_CW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [c_CW-1:0] c_TOP = c_CW'(SCROLL_DIV - 1);

  logic [c_CW-1:0] cnt_q, cnt_d;

  assign w_tick = w_active && (cnt_q == c_TOP);

  always_comb begin
    cnt_d = '0;
    if (!load_i && w_active && !w_manual && !w_tick) begin
      cnt_d = cnt_q + c_CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign w_tick = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    if (load_i) begin
      shadow_d = result_i;
      carry_d  = carry_i;
      idx_d    = '0;
      state_d  = c_S_SHOW;
    end else if (w_active) begin
      // unlock re-arms first; a simultaneous next is consumed by LOCKED
      if (state_q == c_S_LOCKED && unlock_i) begin
        state_d = c_S_SHOW;
      end
      if (w_manual || w_tick) begin
        if (idx_q == c_LAST) begin
          state_d = c_S_DONE;
        end else begin
          idx_d = idx_q + c_IW'(1);
          if (w_manual) begin
            state_d = c_S_LOCKED;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= c_S_IDLE;
      shadow_q <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
    end
  end

  assign out_o      = shadow_q[{idx_q, 3'b000} +: 8];
  assign byte_idx_o = idx_q;
  assign carryled_o = carry_q;
  assign busy_o     = w_active;
  assign done_o     = (state_q == c_S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_result_byte_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_byte_reader
// Bench for result_byte_reader: directed scenarios plus random stimulus
// compared every cycle against a behavioural readout model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_result_byte_reader;

  localparam int WIDTH = 32;
  localparam int DIV   = 4;
  localparam int NB    = WIDTH / 8;

  logic        clk = 1'b0;
  logic        rst, load, nxt, unlock, carry;
  logic [31:0] result;
  logic [7:0]  out;
  logic [1:0]  idx;
  logic        carryled, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model: the captured word and where the reader is in it
  logic [31:0] m_word;
  bit          m_carry, m_active, m_locked, m_done;
  int          m_idx, m_cnt;

  always #5 clk = ~clk;

  result_byte_reader #(.WIDTH(WIDTH), .SCROLL_DIV(DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .result_i   (result),
    .carry_i    (carry),
    .next_i     (nxt),
    .unlock_i   (unlock),
    .out_o      (out),
    .byte_idx_o (idx),
    .carryled_o (carryled),
    .busy_o     (busy),
    .done_o     (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit ld, input bit nx, input bit ul,
                            input logic [31:0] res, input bit c);
    bit tick, manual;
    tick = 1'b0;
`ifdef AUTO_SCROLL_EN
    tick = m_active && (m_cnt == DIV - 1);
`endif
    if (r) begin
      m_word = '0; m_carry = 0; m_idx = 0; m_cnt = 0;
      m_active = 0; m_locked = 0; m_done = 0;
    end else if (ld) begin
      m_word = res; m_carry = c; m_idx = 0; m_cnt = 0;
      m_active = 1; m_locked = 0; m_done = 0;
    end else if (m_active) begin
      manual = !m_locked && nx;
      if (m_locked && ul) m_locked = 0;
      if (manual || tick) begin
        if (m_idx == NB - 1) begin
          m_active = 0; m_locked = 0; m_done = 1;
        end else begin
          m_idx++;
          if (manual) m_locked = 1;
        end
      end
      if (!m_active || manual || tick) m_cnt = 0;
      else m_cnt++;
    end
  endtask

  task automatic cyc(input bit r, input bit ld, input bit nx, input bit ul,
                     input logic [31:0] res, input bit c);
    logic [31:0] exp_out;
    rst = r; load = ld; nxt = nx; unlock = ul; result = res; carry = c;
    @(posedge clk);
    model_edge(r, ld, nx, ul, res, c);
    #1;
    exp_out = (m_word >> (8 * m_idx)) & 32'hFF;
    check("out",      {24'd0, out},      exp_out);
    check("byte_idx", {30'd0, idx},      m_idx);
    check("carryled", {31'd0, carryled}, {31'd0, m_carry});
    check("busy",     {31'd0, busy},     {31'd0, m_active});
    check("done",     {31'd0, done},     {31'd0, m_done});
  endtask

  logic [7:0] scroll_tbl [4];

  initial begin
    rst = 1'b0; load = 1'b0; nxt = 1'b0; unlock = 1'b0; carry = 1'b0; result = '0;
    #2;

    // reset held two cycles while load is asserted
    cyc(1, 1, 0, 0, 32'hFFFF_FFFF, 1);
    cyc(1, 1, 0, 0, 32'hFFFF_FFFF, 1);
    check("rst_out",  {24'd0, out}, 32'h00);
    check("rst_idx",  {30'd0, idx}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_cled", {31'd0, carryled}, 32'd0);

    cyc(0, 1, 0, 0, 32'h89AB_CDEF, 1);
    check("ld_out",  {24'd0, out}, 32'hEF);
    check("ld_busy", {31'd0, busy}, 32'd1);
    check("ld_cled", {31'd0, carryled}, 32'd1);

`ifndef AUTO_SCROLL_EN
    // held next gives exactly one advance
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 1, 0, 32'h0, 0);
      check("hold_out", {24'd0, out}, 32'hCD);
      check("hold_idx", {30'd0, idx}, 32'd1);
    end
    cyc(0, 0, 1, 1, 32'h0, 0);
    check("both_out", {24'd0, out}, 32'hCD);
    cyc(0, 0, 0, 1, 32'h0, 0);
    cyc(0, 0, 1, 0, 32'h0, 0);
    check("b2_out", {24'd0, out}, 32'hAB);
    cyc(0, 0, 0, 1, 32'h0, 0);
    cyc(0, 0, 1, 0, 32'h0, 0);
    check("b3_out", {24'd0, out}, 32'h89);
    cyc(0, 0, 0, 1, 32'h0, 0);
    cyc(0, 0, 1, 0, 32'h0, 0);
    check("end_done", {31'd0, done}, 32'd1);
    check("end_out",  {24'd0, out}, 32'h89);
    check("end_busy", {31'd0, busy}, 32'd0);
    cyc(0, 0, 0, 1, 32'h0, 0);
    cyc(0, 0, 1, 0, 32'h0, 0);
    check("done_hold_idx", {30'd0, idx}, 32'd3);

    // reload while locked at byte 2, then reset from SHOW
    cyc(0, 1, 0, 0, 32'h89AB_CDEF, 0);
    cyc(0, 0, 1, 0, 32'h0, 0);
    cyc(0, 0, 0, 1, 32'h0, 0);
    cyc(0, 0, 1, 0, 32'h0, 0);
    check("lk2_idx", {30'd0, idx}, 32'd2);
    cyc(0, 1, 0, 0, 32'h0000_0000, 0);
    check("rl_out",  {24'd0, out}, 32'h00);
    check("rl_idx",  {30'd0, idx}, 32'd0);
    check("rl_busy", {31'd0, busy}, 32'd1);
    cyc(1, 0, 1, 0, 32'h0, 0);
    check("rst2_busy", {31'd0, busy}, 32'd0);
    check("rst2_idx",  {30'd0, idx}, 32'd0);
`else
    scroll_tbl[0] = 8'h44; scroll_tbl[1] = 8'h33;
    scroll_tbl[2] = 8'h22; scroll_tbl[3] = 8'h11;
    cyc(0, 1, 0, 0, 32'h1122_3344, 0);
    check("as_out0", {24'd0, out}, 32'h44);
    for (int t = 1; t <= 16; t++) begin
      cyc(0, 0, 0, 0, 32'h0, 0);
      if (t == 3) check("as_hold", {24'd0, out}, 32'h44);
      if (t % 4 == 0 && t < 16) check("as_out", {24'd0, out}, {24'd0, scroll_tbl[t / 4]});
      if (t == 16) begin
        check("as_done", {31'd0, done}, 32'd1);
        check("as_last", {24'd0, out}, 32'h11);
      end
    end
`endif

    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0,
          1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
          $urandom, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
